im_loader: RTL and testbench
============================

Name: im_loader

Overview:
Writer side of the instruction-memory interface. It accepts a program image over a byte-wide valid/ready stream and writes it into the IM array from address 0 upward. It holds the processor (PC and RegFile write enables) for the whole transfer, checks a trailing checksum, and then releases the core with a one-cycle PC-restart pulse. It sits between the host stream and the IM write port, alongside MIPSPC.

Parameters:
IM_ADDR_W_m1, 7, IM address width minus 1 (256-entry IM)
IM_DATA_W_m1, 7, IM data width minus 1 (8-bit instructions)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE, DONE or ERR
byte_valid  input  1  stream byte present
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte this cycle
im_we  output  1  IM write strobe, one cycle per payload byte
im_waddr  output  IM_ADDR_W_m1+1  IM write address
im_wdata  output  IM_DATA_W_m1+1  IM write data
cpu_hold  output  1  freeze PC/RegFile/DM writes while high
pc_restart  output  1  one-cycle pulse forcing PC to 0 on release
done  output  1  level: last load succeeded
err  output  1  level: last load failed the checksum

Behaviour:
- Reset: state=IDLE; byte_ready=0, im_we=0, im_waddr=0, im_wdata=0, cpu_hold=0, pc_restart=0, done=0, err=0; count and sum cleared. Reset mid-transfer aborts at once; already-written IM contents are not touched.
- Handshake: a transfer occurs when byte_valid && byte_ready. byte_ready is a registered output, 1 only in LEN, DATA and CSUM. byte_data is ignored otherwise.
- Frame format: LEN byte L (payload count = L+1, so 0 means 1 and 255 means 256), then L+1 payload bytes, then a CSUM byte. A frame is valid when (sum of payload + CSUM) mod 256 == 0.
- States:
  - IDLE/DONE/ERR --start--> LEN. On that edge: cpu_hold=1, done=0, err=0, sum=0, addr=0.
  - LEN --xfer--> DATA. count=L.
  - DATA: each transfer writes the byte. On the next cycle im_we=1, im_waddr=addr, im_wdata=byte (1-cycle registered latency). Then addr+=1 and sum+=byte (mod 256). When count==0 on the transfer, go to CSUM; otherwise count-=1.
  - CSUM --xfer, (sum+byte)==0--> DONE: done=1, cpu_hold=0, pc_restart=1 for exactly that first DONE cycle.
  - CSUM --xfer, mismatch--> ERR: err=1, cpu_hold stays 1, no pc_restart.
- start while in LEN/DATA/CSUM is ignored.
- Address wrap: with L=255, the last write goes to address 255. The address counter may wrap to 0 internally but is never used for a write after that.
- byte_valid may drop at any point; the state holds with no timeout. cpu_hold stays asserted throughout.
- im_we never asserts in IDLE, LEN, CSUM, DONE or ERR, apart from the registered write of the last payload byte, which lands in the first CSUM cycle.
- An ERR image is left in the IM. The core remains held until a subsequent successful load.

Decomposition:
- Shared package holds the state encoding (IDLE, LEN, DATA, CSUM, DONE, ERR as 3-bit localparams) and the IM width constants shared with IM/MIPSPC.
- One natural sub-module, im_loader_csum: an 8-bit running-sum accumulator with clear, add-enable and zero-check. The rest is the single FSM plus counters.

Test Plan:
1. After reset, no stimulus: all outputs are 0 and byte_ready=0 for 10 cycles. Bytes offered while IDLE are not consumed.
2. start, then stream 0x02,0x11,0x22,0x33,0x9A: IM writes 0:0x11, 1:0x22, 2:0x33, each one cycle after its transfer. Then done=1, cpu_hold falls, and a single pc_restart pulse is seen.
3. Same frame with CSUM 0x9B: IM still holds 0x11/0x22/0x33, err=1, done=0, cpu_hold stays 1, no pc_restart.
4. L=0xFF with 256 payload bytes equal to their address (0..255) and CSUM 0x80: last write is 255:0xFF, done=1, and no write goes to address 0 after the first.
5. In scenario 2, deassert byte_valid for 7 cycles between 0x22 and 0x33, and pulse start during the gap: the loader stalls and start is ignored; the result is identical to scenario 2.
6. Assert rst after the second payload byte: the next cycle has all outputs at 0. A fresh start with a full frame then completes normally with done=1.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared constants for the instruction-memory loader: IM geometry
// (also used by IM and MIPSPC) and the loader state encoding.
package im_loader_pkg;

    localparam int IM_ADDR_W_m1 = 7;   // 256-entry IM
    localparam int IM_DATA_W_m1 = 7;   // 8-bit instructions

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LEN  = ST_LEN,
        DATA = ST_DATA,
        CSUM = ST_CSUM,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } loadState_t;

    // States from which a new load may be launched.
    function automatic logic canStart(loadState_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/im_loader_csum.sv
// 8-bit running-sum accumulator. The zero flag reports whether the
// candidate checksum byte would bring the accumulated sum to 0 mod 256.
module im_loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       addEn,
    input  logic [7:0] addByte,
    input  logic [7:0] chkByte,
    output logic [7:0] sum,
    output logic       zero
);

    logic [7:0] total;

    // Accumulate payload bytes; clear at the start of every frame.
    always_ff @(posedge clk) begin
        if (rst || clr) sum <= 8'd0;
        else if (addEn) sum <= sum + addByte;
    end

    // Combinational check of sum + checksum byte, wrapping at 8 bits.
    always_comb begin
        total = sum + chkByte;
        zero  = (total == 8'd0);
    end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: takes a LEN/payload/CSUM frame from a byte
// stream, writes the payload into IM from address 0, holds the core during
// the transfer and releases it with a PC-restart pulse on a good checksum.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int IM_ADDR_W_m1 = im_loader_pkg::IM_ADDR_W_m1,
    parameter int IM_DATA_W_m1 = im_loader_pkg::IM_DATA_W_m1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  im_we,
    output logic [IM_ADDR_W_m1:0] im_waddr,
    output logic [IM_DATA_W_m1:0] im_wdata,
    output logic                  cpu_hold,
    output logic                  pc_restart,
    output logic                  done,
    output logic                  err
);

    loadState_t            state;
    logic [7:0]            count;
    logic [IM_ADDR_W_m1:0] addr;
    logic                  xfer;
    logic                  launch;
    logic                  sumAdd;
    logic [7:0]            sum;
    logic                  sumZero;

    assign xfer   = byte_valid && byte_ready;
    assign launch = start && canStart(state);
    assign sumAdd = xfer && (state == DATA);

    im_loader_csum uCsum (
        .clk     (clk),
        .rst     (rst),
        .clr     (launch),
        .addEn   (sumAdd),
        .addByte (byte_data),
        .chkByte (byte_data),
        .sum     (sum),
        .zero    (sumZero)
    );

    // Frame FSM with registered handshake, IM write port and core control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 8'd0;
            addr       <= '0;
            byte_ready <= 1'b0;
            im_we      <= 1'b0;
            im_waddr   <= '0;
            im_wdata   <= '0;
            cpu_hold   <= 1'b0;
            pc_restart <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            im_we      <= 1'b0;
            pc_restart <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        addr       <= '0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        count <= byte_data;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        im_we    <= 1'b1;
                        im_waddr <= addr;
                        im_wdata <= byte_data[IM_DATA_W_m1:0];
                        // May wrap to 0 after the 256th byte; never written again.
                        addr     <= addr + 1'b1;
                        if (count == 8'd0) state <= CSUM;
                        else count <= count - 8'd1;
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (sumZero) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
                            pc_restart <= 1'b1;
                        end else begin
                            // Core stays held until a later load succeeds.
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a cycle table for the basic frame plus
// hand-written sequences for bad checksum, full-size frame, stalls and reset.
module tb_im_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       im_we;
    logic [7:0] im_waddr;
    logic [7:0] im_wdata;
    logic       cpu_hold;
    logic       pc_restart;
    logic       done;
    logic       err;

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    im_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .pc_restart (pc_restart),
        .done       (done),
        .err        (err)
    );

    // IM model and event counters fed from the write port
    logic [7:0] imModel [256];
    int wrCnt = 0, addr0Cnt = 0, restartCnt = 0;
    logic [7:0] lastAddr = 8'd0, lastData = 8'd0;

    always @(negedge clk) begin
        if (im_we) begin
            imModel[im_waddr] <= im_wdata;
            wrCnt    <= wrCnt + 1;
            if (im_waddr == 8'd0) addr0Cnt <= addr0Cnt + 1;
            lastAddr <= im_waddr;
            lastData <= im_wdata;
        end
        if (pc_restart) restartCnt <= restartCnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte; returns after the edge where it was accepted.
    task automatic sendByte(input logic [7:0] d);
        logic ok;
        byte_valid = 1'b1;
        byte_data  = d;
        for (int i = 0; i < 20; i++) begin
            ok = byte_ready;
            tick();
            if (ok) return;
        end
        chk("byte accept timeout", 32'd0, 32'd1);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    typedef struct {
        logic       st;
        logic       v;
        logic [7:0] d;
        logic       rdy, we;
        logic [7:0] wa, wd;
        logic       hold, pcr, dn, er;
    } vec_t;

    vec_t tbl [7];
    int   r0, w0, a0;

    initial begin
        // start, valid, data | ready, we, waddr, wdata, hold, restart, done, err
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 8'h01, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h02, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h9A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        tick(); tick();
        rst = 1'b0;

        // 1: idle after reset, offered bytes are not consumed
        byte_valid = 1'b1; byte_data = 8'h55;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle outputs",
                {byte_ready, im_we, im_waddr, im_wdata, cpu_hold, pc_restart, done, err}, 32'd0);
        end
        byte_valid = 1'b0;

        // 2: basic good frame, cycle by cycle
        r0 = restartCnt;
        for (int i = 0; i < 7; i++) begin
            start = tbl[i].st; byte_valid = tbl[i].v; byte_data = tbl[i].d;
            tick();
            chk($sformatf("t%0d ready", i), byte_ready, tbl[i].rdy);
            chk($sformatf("t%0d we", i), im_we, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("t%0d waddr", i), im_waddr, tbl[i].wa);
                chk($sformatf("t%0d wdata", i), im_wdata, tbl[i].wd);
            end
            chk($sformatf("t%0d hold", i), cpu_hold, tbl[i].hold);
            chk($sformatf("t%0d restart", i), pc_restart, tbl[i].pcr);
            chk($sformatf("t%0d done", i), done, tbl[i].dn);
            chk($sformatf("t%0d err", i), err, tbl[i].er);
        end
        start = 1'b0; byte_valid = 1'b0;
        tick();
        chk("s2 restart pulses", restartCnt - r0, 1);

        // 3: same payload, bad checksum
        r0 = restartCnt;
        pulseStart();
        sendByte(8'h02); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h9B);
        byte_valid = 1'b0;
        tick(); tick();
        chk("s3 im0", imModel[0], 8'h11);
        chk("s3 im1", imModel[1], 8'h22);
        chk("s3 im2", imModel[2], 8'h33);
        chk("s3 err", err, 1);
        chk("s3 done", done, 0);
        chk("s3 hold", cpu_hold, 1);
        chk("s3 restart", restartCnt - r0, 0);

        // 5: stall between 0x22 and 0x33 with a start pulse in the gap
        r0 = restartCnt;
        imModel[0] = 8'h00; imModel[1] = 8'h00; imModel[2] = 8'h00;
        pulseStart();
        sendByte(8'h02); sendByte(8'h11); sendByte(8'h22);
        byte_valid = 1'b0;
        tick();
        w0 = wrCnt;
        for (int i = 0; i < 6; i++) begin
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        chk("s5 gap writes", wrCnt - w0, 0);
        chk("s5 gap ready", byte_ready, 1);
        chk("s5 gap hold", cpu_hold, 1);
        sendByte(8'h33); sendByte(8'h9A);
        byte_valid = 1'b0;
        tick(); tick();
        chk("s5 im0", imModel[0], 8'h11);
        chk("s5 im1", imModel[1], 8'h22);
        chk("s5 im2", imModel[2], 8'h33);
        chk("s5 done", done, 1);
        chk("s5 err", err, 0);
        chk("s5 hold", cpu_hold, 0);
        chk("s5 restart", restartCnt - r0, 1);

        // 4: 256-byte frame, payload = address
        r0 = restartCnt; w0 = wrCnt; a0 = addr0Cnt;
        pulseStart();
        sendByte(8'hFF);
        for (int i = 0; i < 256; i++) sendByte(8'(i));
        sendByte(8'h80);
        byte_valid = 1'b0;
        tick(); tick();
        begin
            int bad = 0;
            for (int i = 0; i < 256; i++) if (imModel[i] !== 8'(i)) bad++;
            chk("s4 image mismatches", bad, 0);
        end
        chk("s4 writes", wrCnt - w0, 256);
        chk("s4 addr0 writes", addr0Cnt - a0, 1);
        chk("s4 last addr", lastAddr, 8'hFF);
        chk("s4 last data", lastData, 8'hFF);
        chk("s4 done", done, 1);
        chk("s4 restart", restartCnt - r0, 1);

        // 6: reset mid-transfer, then a fresh frame
        pulseStart();
        sendByte(8'h02); sendByte(8'hA1); sendByte(8'hA2);
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6 reset outputs",
            {byte_ready, im_we, im_waddr, im_wdata, cpu_hold, pc_restart, done, err}, 32'd0);
        r0 = restartCnt;
        pulseStart();
        sendByte(8'h02); sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'hFA);
        byte_valid = 1'b0;
        tick(); tick();
        chk("s6 im0", imModel[0], 8'h01);
        chk("s6 im2", imModel[2], 8'h03);
        chk("s6 done", done, 1);
        chk("s6 hold", cpu_hold, 0);
        chk("s6 restart", restartCnt - r0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
